// File: rtl/wb_arbiter_if.sv
// wb_arbiter_if: result-stream bus between the functional-unit outputs and the
// writeback arbiter. The master side is the FU / requester side; the slave side
// is the arbiter, which also drives the single WB result port.
interface wb_arbiter_if #(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = 32,
  parameter int ROB_IDX_W = 3
);
  logic [NUM_REQ-1:0]           req_valid;
  logic [NUM_REQ*DATA_W-1:0]    req_data;
  logic [NUM_REQ*ROB_IDX_W-1:0] req_rob_idx;
  logic [NUM_REQ-1:0]           req_ready;
  logic                         flush;
  logic                         WB_out_valid;
  logic [DATA_W-1:0]            WB_out_data;
  logic [ROB_IDX_W-1:0]         WB_out_rob_idx;
  logic [NUM_REQ-1:0]           WB_out_src;

  modport master (
    output req_valid, req_data, req_rob_idx, flush,
    input  req_ready, WB_out_valid, WB_out_data, WB_out_rob_idx, WB_out_src
  );

  modport slave (
    input  req_valid, req_data, req_rob_idx, flush,
    output req_ready, WB_out_valid, WB_out_data, WB_out_rob_idx, WB_out_src
  );
endinterface

// File: rtl/wb_arbiter.sv
// wb_arbiter: shares the EXE->WB result port among NUM_REQ result streams.
// Each requester owns a one-entry holding buffer; one full buffer is granted
// per cycle and driven onto the WB port.
// Build option: define WB_ARB_RR_EN for round-robin arbitration with a
// rotating pointer; without it the lowest full index always wins.
module wb_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = 32,
  parameter int ROB_IDX_W = 3
) (
  input  logic       clk,
  input  logic       rst,
  wb_arbiter_if.slave bus
);
  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]   buf_full;
  logic [DATA_W-1:0]    buf_data [NUM_REQ];
  logic [ROB_IDX_W-1:0] buf_rob  [NUM_REQ];

  logic [NUM_REQ-1:0]   grant;
  logic [NUM_REQ-1:0]   xfer;
  logic [IDX_W-1:0]     gnt_idx;
  logic [IDX_W-1:0]     ptr;
  logic                 any_grant;

`ifdef WB_ARB_RR_EN
  logic [IDX_W-1:0] ptr_next;

  // Next scan start is one past the winner, wrapping at NUM_REQ-1.
  assign ptr_next = (gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;

  // Pointer advances only when a result actually leaves on the WB port.
  always_ff @(posedge clk) begin
    if (rst)                   ptr <= '0;
    else if (bus.WB_out_valid) ptr <= ptr_next;
  end
`else
  assign ptr = '0;
`endif

  // Grant the first full buffer scanning upward from ptr; uses buffer state only,
  // so req_ready never depends combinationally on req_valid.
  always_comb begin
    int s;
    s         = 0;
    grant     = '0;
    gnt_idx   = '0;
    any_grant = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      s = int'(ptr) + k;
      if (s >= NUM_REQ) s = s - NUM_REQ;
      if (!any_grant && buf_full[s[IDX_W-1:0]]) begin
        any_grant             = 1'b1;
        gnt_idx               = s[IDX_W-1:0];
        grant[s[IDX_W-1:0]]   = 1'b1;
      end
    end
  end

  assign bus.WB_out_valid   = any_grant && !bus.flush;
  assign bus.WB_out_data    = any_grant ? buf_data[gnt_idx] : '0;
  assign bus.WB_out_rob_idx = any_grant ? buf_rob[gnt_idx]  : '0;
  assign bus.WB_out_src     = bus.WB_out_valid ? grant : '0;

  // A buffer can accept when empty, when it is draining this cycle, or on flush.
  assign bus.req_ready = ~buf_full | grant | {NUM_REQ{bus.flush}};
  assign xfer          = bus.req_valid & bus.req_ready;

  // Valid bits: flush empties everything; a new transfer wins over a drain.
  always_ff @(posedge clk) begin
    if (rst)            buf_full <= '0;
    else if (bus.flush) buf_full <= '0;
    else                buf_full <= xfer | (buf_full & ~grant);
  end

  // Payload registers load on transfer and are otherwise left untouched.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_REQ; i++) begin
      if (xfer[i] && !bus.flush) begin
        buf_data[i] <= bus.req_data[i*DATA_W +: DATA_W];
        buf_rob[i]  <= bus.req_rob_idx[i*ROB_IDX_W +: ROB_IDX_W];
      end
    end
  end
endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: self-checking bench for wb_arbiter (either build of
// WB_ARB_RR_EN). Accepted results are queued per source and matched against
// what appears on the WB port; grant/ready come from a small reference model.
module tb_wb_arbiter;
  localparam int N  = 4;
  localparam int DW = 32;
  localparam int RW = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  wb_arbiter_if #(.NUM_REQ(N), .DATA_W(DW), .ROB_IDX_W(RW)) bus ();
  wb_arbiter #(.NUM_REQ(N), .DATA_W(DW), .ROB_IDX_W(RW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model state and per-source scoreboard queues.
  logic [N-1:0]      m_full;
  int                m_ptr;
  logic [DW+RW-1:0]  sbq [N][$];
  logic [N-1:0]      e_grant;
  int                e_gi;
  logic [N-1:0]      e_ready;

  task automatic model_eval();
    int start;
    logic [1:0] j;
`ifdef WB_ARB_RR_EN
    start = m_ptr;
`else
    start = 0;
`endif
    e_grant = '0;
    e_gi    = -1;
    for (int k = 0; k < N; k++) begin
      j = 2'((start + k) % N);
      if (e_gi < 0 && m_full[j]) e_gi = int'(j);
    end
    if (e_gi >= 0) e_grant[2'(e_gi)] = 1'b1;
    e_ready = ~m_full | e_grant | {N{bus.flush}};
  endtask

  task automatic drive(input logic [N-1:0] v, input logic f);
    bus.req_valid = v;
    bus.flush     = f;
    for (int i = 0; i < N; i++) begin
      bus.req_data[i*DW +: DW]    = $urandom;
      bus.req_rob_idx[i*RW +: RW] = 3'($urandom_range(0, 7));
    end
  endtask

  // One clock cycle: compare at negedge, then advance the model at posedge.
  task automatic tick();
    logic             e_valid;
    int               si;
    logic [DW+RW-1:0] e;
    model_eval();
    e_valid = (e_grant != '0) && !bus.flush;
    @(negedge clk);
    chk("req_ready", bus.req_ready, e_ready);
    chk("wb_valid", bus.WB_out_valid, e_valid);
    chk("wb_src", bus.WB_out_src, e_valid ? e_grant : '0);
    if (e_grant == '0) begin
      chk("wb_data_idle", bus.WB_out_data, 0);
      chk("wb_rob_idle", bus.WB_out_rob_idx, 0);
    end
    if (bus.WB_out_valid) begin
      si = -1;
      for (int i = 0; i < N; i++) if (bus.WB_out_src[i]) si = i;
      if (si < 0 || sbq[si].size() == 0) begin
        chk("wb_unexpected_result", 1, 0);
      end else begin
        e = sbq[si].pop_front();
        chk("wb_data", bus.WB_out_data, e[DW+RW-1:RW]);
        chk("wb_rob", bus.WB_out_rob_idx, e[RW-1:0]);
      end
    end
    @(posedge clk);
    if (rst || bus.flush) begin
      m_full = '0;
      for (int i = 0; i < N; i++) sbq[i].delete();
      if (rst) m_ptr = 0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (bus.req_valid[i] && e_ready[i]) begin
          m_full[i] = 1'b1;
          sbq[i].push_back({bus.req_data[i*DW +: DW], bus.req_rob_idx[i*RW +: RW]});
        end else if (e_grant[i]) begin
          m_full[i] = 1'b0;
        end
      end
      if (e_gi >= 0) m_ptr = (e_gi + 1) % N;
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive('0, 1'b0);
    tick();
    rst = 1'b0;
  endtask

  initial begin
    logic [N-1:0] one;
    logic [N-1:0] exp_g;
    int pending;
    one    = 4'b0001;
    m_full = '0;
    m_ptr  = 0;
    rst    = 1'b1;
    drive('0, 1'b0);
    tick();
    tick();
    rst = 1'b0;

    // Idle after reset.
    #1;
    chk("reset_ready", bus.req_ready, 4'b1111);
    chk("reset_valid", bus.WB_out_valid, 0);
    repeat (3) tick();

    // Single ALU result.
    drive(4'b0001, 1'b0);
    bus.req_data[DW-1:0]    = 32'h0000_00AA;
    bus.req_rob_idx[RW-1:0] = 3'd3;
    tick();
    drive('0, 1'b0);
    #1;
    chk("alu_valid", bus.WB_out_valid, 1);
    chk("alu_data", bus.WB_out_data, 32'hAA);
    chk("alu_rob", bus.WB_out_rob_idx, 3);
    chk("alu_src", bus.WB_out_src, 4'b0001);
    tick();
    #1;
    chk("alu_after_valid", bus.WB_out_valid, 0);
    tick();

    // All four requesters valid every cycle from reset.
    do_reset();
    drive(4'b1111, 1'b0);
    for (int c = 0; c < 9; c++) begin
      #1;
`ifdef WB_ARB_RR_EN
      exp_g = (c == 0) ? 4'b0000 : one << ((c - 1) % N);
`else
      exp_g = (c == 0) ? 4'b0000 : one;
`endif
      chk("all_src", bus.WB_out_src, exp_g);
      chk("all_ready", bus.req_ready, (c == 0) ? 4'b1111 : exp_g);
      tick();
      drive(4'b1111, 1'b0);
    end
    drive('0, 1'b0);
    repeat (5) tick();

    // Flush with MDR and FPU buffers full and a new LSU request.
    do_reset();
    drive(4'b1010, 1'b0);
    tick();
    drive(4'b0100, 1'b1);
    #1;
    chk("flush_valid", bus.WB_out_valid, 0);
    tick();
    drive('0, 1'b0);
    #1;
    chk("flush_next_valid", bus.WB_out_valid, 0);
    chk("flush_next_ready", bus.req_ready, 4'b1111);
    repeat (3) tick();

    // Pointer at 3 with only buffer 0 full.
    do_reset();
    drive(4'b0100, 1'b0);
    tick();
    drive(4'b0001, 1'b0);
    tick();
    drive('0, 1'b0);
    #1;
    chk("ptr3_grant", bus.WB_out_src, 4'b0001);
    tick();
    drive(4'b0111, 1'b0);
    tick();
    drive('0, 1'b0);
    #1;
`ifdef WB_ARB_RR_EN
    chk("ptr1_grant", bus.WB_out_src, 4'b0010);
`else
    chk("ptr1_grant", bus.WB_out_src, 4'b0001);
`endif
    repeat (5) tick();

    // Random traffic with occasional flush and one mid-run reset.
    for (int i = 0; i < 300; i++) begin
      drive(4'($urandom), ($urandom_range(0, 15) == 0));
      rst = (i == 150);
      tick();
    end
    rst = 1'b0;
    drive('0, 1'b0);
    repeat (6) tick();
    pending = 0;
    for (int i = 0; i < N; i++) pending += sbq[i].size();
    chk("drained", pending, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
